// File: rtl/game_tick_scheduler.sv
// Purpose : variable-rate game-step enable; period shrinks by STEP_DIV per level down to MIN_DIV.
// Latency : first step_tick lands period_div edges after the IDLE->RUN edge; level lags win_counter by one cycle.
// Backpress: none; pause freezes the period counter, lose parks in HALT until run drops.
//
// Ports: Clk/Rst (async active-high) | run, pause, lose, win_counter from FSM/buttons
//        step_tick (1-cycle enable), level (saturated win count), period_div (period in force),
//        busy (RUN or PAUSE).
// Optional: define GAME_TICK_FASTSIM_EN to scale the divider values down by 2^16 (floored at 2).
module game_tick_scheduler #(
    parameter int          CNT_W     = 26,
    parameter int unsigned BASE_DIV  = 50_000_000,
    parameter int unsigned STEP_DIV  = 2_500_000,
    parameter int unsigned MIN_DIV   = 12_500_000,
    parameter int          MAX_LEVEL = 15
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             run,
    input  logic             pause,
    input  logic [3:0]       win_counter,
    input  logic             lose,
    output logic             step_tick,
    output logic [3:0]       level,
    output logic [CNT_W-1:0] period_div,
    output logic             busy
);

    localparam int PW = CNT_W + 4;

`ifdef GAME_TICK_FASTSIM_EN
    function automatic int unsigned fs_scale(input int unsigned v);
        int unsigned s;
        s = v >> 16;
        return (s < 2) ? 2 : s;
    endfunction

    localparam int unsigned BASE_EFF = fs_scale(BASE_DIV);
    localparam int unsigned STEP_EFF = fs_scale(STEP_DIV);
    localparam int unsigned MIN_EFF  = fs_scale(MIN_DIV);
`else
    localparam int unsigned BASE_EFF = BASE_DIV;
    localparam int unsigned STEP_EFF = STEP_DIV;
    localparam int unsigned MIN_EFF  = MIN_DIV;
`endif

    localparam logic [PW-1:0]    BASE_X = PW'(BASE_EFF);
    localparam logic [PW-1:0]    STEP_X = PW'(STEP_EFF);
    localparam logic [PW-1:0]    MIN_X  = PW'(MIN_EFF);
    localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_EFF);
    localparam logic [3:0]       MAX_L  = 4'(MAX_LEVEL);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, div_nxt;
    logic             tick_nxt;
    logic [PW-1:0]    prod, diff;
    logic [CNT_W-1:0] p_lvl;

    // P(level): product is formed wide so 15*STEP never wraps; an underflow
    // (prod >= BASE) or anything below the floor clamps to MIN.
    always_comb begin
        prod  = {{CNT_W{1'b0}}, level} * STEP_X;
        diff  = BASE_X - prod;
        p_lvl = CNT_W'(MIN_X);
        if ((prod < BASE_X) && (diff >= MIN_X))
            p_lvl = CNT_W'(diff);
    end

    // Exit priority from RUN/PAUSE: run=0, then lose, then pause. The
    // unpaused branch is shared so the resume edge counts like a RUN edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = period_div;
        tick_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                div_nxt = p_lvl;
                if (run && !lose)
                    state_nxt = RUN;
            end
            RUN, PAUSE: begin
                if (!run) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (lose) begin
                    state_nxt = HALT;
                    cnt_nxt   = '0;
                end else if (pause) begin
                    state_nxt = PAUSE;
                end else begin
                    state_nxt = RUN;
                    if (cnt == period_div - CNT_W'(1)) begin
                        // New period only takes effect at the wrap.
                        cnt_nxt  = '0;
                        tick_nxt = 1'b1;
                        div_nxt  = p_lvl;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            HALT: begin
                cnt_nxt = '0;
                if (!run)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            period_div <= BASE_C;
            step_tick  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            period_div <= div_nxt;
            step_tick  <= tick_nxt;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            level <= '0;
        else
            level <= (win_counter > MAX_L) ? MAX_L : win_counter;
    end

    assign busy = (state == RUN) || (state == PAUSE);

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Purpose : directed check of tick spacing, level speed-up, pause, lose/HALT and async reset.
// Latency : tick edges are measured relative to the IDLE->RUN edge (edge 0).
// Backpress: n/a.
module tb_game_tick_scheduler;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       run = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] win_counter = 4'd0;
    logic       lose = 1'b0;
    logic       step_tick;
    logic [3:0] level;
    logic [7:0] period_div;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0;
    int t;

    game_tick_scheduler #(
        .CNT_W(8), .BASE_DIV(20), .STEP_DIV(4), .MIN_DIV(8), .MAX_LEVEL(15)
    ) dut (
        .Clk(Clk), .Rst(Rst), .run(run), .pause(pause), .win_counter(win_counter),
        .lose(lose), .step_tick(step_tick), .level(level), .period_div(period_div),
        .busy(busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Advance until `rel` edges past edge 0 have been seen.
    task automatic goto(input int rel);
        while (cyc - e0 < rel) step();
    endtask

    // Returns the edge index (relative to e0) of the next tick, or -1 on timeout.
    task automatic wait_tick(input int max, output int rel);
        bit found;
        found = 1'b0;
        rel   = -1;
        for (int i = 0; i < max; i++) begin
            if (!found) begin
                step();
                if (step_tick) begin
                    found = 1'b1;
                    rel   = cyc - e0;
                end
            end
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_tick", step_tick, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_div", period_div, 20);
        step();
        Rst = 1'b0;
        step();
        run = 1'b1;
        step();
        e0 = cyc;
        check("run_busy", busy, 1);
        check("run_div", period_div, 20);

        // Level 0: period 20
        wait_tick(40, t); check("tick_20", t, 20);
        step();           check("tick_width", step_tick, 0);
        goto(24);
        win_counter = 4'd2;
        wait_tick(40, t); check("tick_40", t, 40);
        check("div_12", period_div, 12);
        check("level_2", level, 2);
        wait_tick(40, t); check("tick_52", t, 52);
        wait_tick(40, t); check("tick_64", t, 64);

        // Level 5 underflows to floor, level 15 saturates at floor
        win_counter = 4'd5;
        wait_tick(40, t); check("tick_76", t, 76);
        check("level_5", level, 5);
        check("div_8", period_div, 8);
        wait_tick(40, t); check("tick_84", t, 84);
        wait_tick(40, t); check("tick_92", t, 92);
        win_counter = 4'd15;
        wait_tick(40, t); check("tick_100", t, 100);
        check("level_15", level, 15);
        check("div_8_l15", period_div, 8);
        wait_tick(40, t); check("tick_108", t, 108);
        win_counter = 4'd0;
        wait_tick(40, t); check("tick_116", t, 116);
        check("div_back_20", period_div, 20);

        // Pause 7 cycles at cnt=10: tick 136 moves to 143
        goto(126);
        pause = 1'b1;
        step();
        check("pause_busy", busy, 1);
        repeat (6) step();
        check("pause_no_tick", step_tick, 0);
        pause = 1'b0;
        wait_tick(40, t); check("tick_143", t, 143);
        wait_tick(40, t); check("tick_163", t, 163);

        // lose on the would-be tick edge
        goto(182);
        lose = 1'b1;
        step();
        check("lose_no_tick", step_tick, 0);
        check("halt_busy", busy, 0);
        lose = 1'b0;
        wait_tick(25, t); check("halt_silent", t, -1);
        run = 1'b0;
        step();
        check("idle_busy", busy, 0);
        run = 1'b1;
        step();
        e0 = cyc;
        check("rerun_busy", busy, 1);
        wait_tick(40, t); check("rerun_tick_20", t, 20);

        // Async reset mid-period at cnt=13
        win_counter = 4'd3;
        goto(33);
        #2;
        Rst = 1'b1;
        #1;
        check("arst_tick", step_tick, 0);
        check("arst_busy", busy, 0);
        check("arst_level", level, 0);
        check("arst_div", period_div, 20);
        win_counter = 4'd0;
        #2;
        Rst = 1'b0;
        step();
        e0 = cyc;
        check("post_rst_busy", busy, 1);
        wait_tick(40, t); check("post_rst_tick_20", t, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
